// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin pop scheduler for four QoS class FIFOs.
// Per-round service is capped by software weights that are swapped in only between rounds.
module qos_wrr_scheduler #(
  parameter int               NQ          = 4,
  parameter int               WW          = 3,
  parameter logic [NQ*WW-1:0] DEF_WEIGHTS = {3'd1, 3'd2, 3'd3, 3'd4}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NQ-1:0]    emptyFIFO,
  input  logic             almost_full,
  input  logic [NQ*WW-1:0] cfg_weights,
  input  logic             cfg_load,
  output logic [NQ-1:0]    pop,
  output logic             valid_out,
  output logic [1:0]       grant_id,
  output logic             round_done
);

  // state     | meaning
  // S_IDLE    | no serviceable class; active weights follow the shadow copy
  // S_SERVE   | issuing pops within the current round
  // S_ROUND_END | one bubble: clear counters, adopt shadow weights
  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_ROUND_END} state_t;

  localparam int IW = (NQ > 1) ? $clog2(NQ) : 1;

  state_t                state_q, state_d;
  logic [NQ-1:0][WW-1:0] wt_q, wt_d;
  logic [NQ-1:0][WW-1:0] sh_q, sh_d;
  logic [NQ-1:0][WW-1:0] cnt_q, cnt_d;
  logic                  valid_out_q, valid_out_d;
  logic [1:0]            grant_id_q, grant_id_d;
  logic                  round_done_q, round_done_d;

  logic [NQ-1:0] elig;
  logic [NQ-1:0] elig_after;
  logic [NQ-1:0] ready_idle;
  logic [NQ-1:0] pop_int;
  logic [IW-1:0] sel;
  logic [WW-1:0] cnt_inc;
  logic          any_elig;
  logic          any_cnt;

  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      elig[i]       = !emptyFIFO[i] && (wt_q[i] != '0) && (cnt_q[i] < wt_q[i]);
      ready_idle[i] = !emptyFIFO[i] && (sh_q[i] != '0);
      if (cnt_q[i] != '0) any_cnt = 1'b1;
    end
    any_elig = |elig;
    sel = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = IW'(i);
    end
    cnt_inc = cnt_q[sel] + WW'(1);
    // Look ahead past this pop so the round ends with a single bubble cycle.
    elig_after = elig;
    if (cnt_inc >= wt_q[sel]) elig_after[sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wt_q         <= DEF_WEIGHTS;
      sh_q         <= DEF_WEIGHTS;
      cnt_q        <= '0;
      valid_out_q  <= 1'b0;
      grant_id_q   <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wt_q         <= wt_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      valid_out_q  <= valid_out_d;
      grant_id_q   <= grant_id_d;
      round_done_q <= round_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wt_d    = wt_q;
    cnt_d   = cnt_q;
    sh_d    = cfg_load ? cfg_weights : sh_q;
    case (state_q)
      S_IDLE: begin
        wt_d  = sh_q;
        cnt_d = '0;
        if (|ready_idle) state_d = S_SERVE;
      end
      S_SERVE: begin
        if (!almost_full) begin
          if (any_elig) begin
            cnt_d[sel] = cnt_inc;
            if (!(|elig_after)) state_d = S_ROUND_END;
          end else if (any_cnt) begin
            state_d = S_ROUND_END;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ROUND_END: begin
        cnt_d   = '0;
        wt_d    = sh_q;
        state_d = S_SERVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop_int = '0;
    if ((state_q == S_SERVE) && !almost_full && any_elig) pop_int[sel] = 1'b1;
    pop          = reset ? '0 : pop_int;
    valid_out_d  = |pop;
    grant_id_d   = (|pop) ? 2'(sel) : 2'd0;
    round_done_d = (state_q == S_ROUND_END);
  end

  assign valid_out  = valid_out_q;
  assign grant_id   = grant_id_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Directed bench for qos_wrr_scheduler: per-cycle expected pop codes, with
// valid_out/grant_id/round_done expectations derived from the previous cycle's code.
module tb_qos_wrr_scheduler;

  localparam logic [11:0] DEF_W = {3'd1, 3'd2, 3'd3, 3'd4};

  logic        clk;
  logic        reset;
  logic [3:0]  emptyFIFO;
  logic        almost_full;
  logic [11:0] cfg_weights;
  logic        cfg_load;
  logic [3:0]  pop;
  logic        valid_out;
  logic [1:0]  grant_id;
  logic        round_done;

  int n_tests;
  int n_fail;
  int prev_code;  // 0..3 popped class, 8 round-end bubble, 9 other idle cycle
  int seq[$];

  qos_wrr_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .emptyFIFO   (emptyFIFO),
    .almost_full (almost_full),
    .cfg_weights (cfg_weights),
    .cfg_load    (cfg_load),
    .pop         (pop),
    .valid_out   (valid_out),
    .grant_id    (grant_id),
    .round_done  (round_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with inputs already set; leaves at the next falling edge.
  task automatic cycle(input string tag, input int code);
    logic [3:0] ep;
    logic       ev;
    logic [1:0] eg;
    logic       erd;
    ep  = (code >= 0 && code < 4) ? (4'b0001 << code) : 4'b0000;
    ev  = (prev_code >= 0 && prev_code < 4);
    eg  = ev ? 2'(prev_code) : 2'd0;
    erd = (prev_code == 8);
    #1;
    chk({tag, "_pop"},   32'(pop),        32'(ep));
    chk({tag, "_valid"}, 32'(valid_out),  32'(ev));
    chk({tag, "_gid"},   32'(grant_id),   32'(eg));
    chk({tag, "_rdone"}, 32'(round_done), 32'(erd));
    prev_code = code;
    @(negedge clk);
  endtask

  task automatic run_seq(input string tag);
    foreach (seq[i]) cycle($sformatf("%s[%0d]", tag, i), seq[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    prev_code   = 9;
    reset       = 1'b1;
    emptyFIFO   = 4'hF;
    almost_full = 1'b0;
    cfg_weights = '0;
    cfg_load    = 1'b0;
    @(negedge clk);

    seq = '{9, 9};
    run_seq("in_reset");

    reset     = 1'b0;
    emptyFIFO = 4'h0;
    seq = '{9, 0,0,0,0,1,1,1,2,2,3,8, 0,0,0,0,1,1,1,2,2,3,8};
    run_seq("dflt");

    emptyFIFO = 4'b0010;
    seq = '{0,0,0,0,2,2,3,8, 0,0,0,0,2,2,3,8};
    run_seq("q1_empty");

    emptyFIFO = 4'h0;
    seq = '{0, 0};
    run_seq("af_pre");
    almost_full = 1'b1;
    seq = '{9, 9, 9};
    run_seq("af_stall");
    almost_full = 1'b0;
    seq = '{0,0,1,1,1,2,2,3,8};
    run_seq("af_post");

    seq = '{0, 0};
    run_seq("cfg_pre");
    cfg_weights = {3'd0, 3'd0, 3'd1, 3'd2};
    cfg_load    = 1'b1;
    seq = '{0};
    run_seq("cfg_ld");
    cfg_load = 1'b0;
    seq = '{0,1,1,1,2,2,3,8, 0,0,1,8, 0,0,1};
    run_seq("cfg_new");

    // load on the ROUND_END cycle: next round still uses the previous shadow
    cfg_weights = DEF_W;
    cfg_load    = 1'b1;
    seq = '{8};
    run_seq("re_ld");
    cfg_load = 1'b0;
    seq = '{0,0,1,8, 0,0};
    run_seq("re_after");

    #1;
    chk("mid_pop", 32'(pop), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_pop", 32'(pop), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_rdone", 32'(round_done), 32'h0);
    reset     = 1'b0;
    prev_code = 9;
    @(negedge clk);
    seq = '{0,0,0,0,1,1,1,2,2,3,8, 0};
    run_seq("post_rst");

    reset     = 1'b1;
    emptyFIFO = 4'hF;
    @(negedge clk);
    reset     = 1'b0;
    prev_code = 9;
    seq = '{9, 9, 9, 9};
    run_seq("idle");
    emptyFIFO = 4'b0111;
    seq = '{9, 3};
    run_seq("wake");
    emptyFIFO = 4'hF;
    seq = '{8, 9, 9};
    run_seq("wake_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
